// File: rtl/memory_pkg.sv
// ---------------------------------------------------------------------------
// memory_pkg
// Shared types and constants for the MEM-stage data memory unit.
//   memState_e  : access FSM states (IDLE, BUSY, DONE)
//   WORD_WIDTH  : data word width in bits
//   BYTE_WIDTH  : byte lane width in bits
//   LANE_LO/HI  : values of Address[0] selecting the low/high byte lane
//   laneEnable  : builds the 2-bit RAM byte-enable for an access
// ---------------------------------------------------------------------------
package memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } memState_e;

    localparam int WORD_WIDTH = 16;
    localparam int BYTE_WIDTH = 8;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    // Word accesses touch both lanes; byte accesses touch only the lane
    // picked by the low address bit.
    function automatic logic [1:0] laneEnable(input logic byteOp, input logic lane);
        logic [1:0] enable;
        if (!byteOp) begin
            enable = 2'b11;
        end else if (lane == LANE_HI) begin
            enable = 2'b10;
        end else begin
            enable = 2'b01;
        end
        return enable;
    endfunction

endpackage

// File: rtl/data_ram.sv
// ---------------------------------------------------------------------------
// data_ram
// DEPTH x 16-bit data RAM with a per-byte write enable and a registered read.
// Contents are never reset.
//   clk_i   : clock, rising edge
//   we_i    : write strobe
//   be_i    : byte enables, bit 0 = bits [7:0], bit 1 = bits [15:8]
//   re_i    : read strobe; rdata_o updates on the following edge
//   addr_i  : word index
//   wdata_i : write data (both lanes; be_i selects which are stored)
//   rdata_o : registered read data
// ---------------------------------------------------------------------------
module data_ram
    import memory_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [1:0]               be_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WORD_WIDTH-1:0]    wdata_i,
    output logic [WORD_WIDTH-1:0]    rdata_o
);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [WORD_WIDTH-1:0] rdata_q;

    // Storage array with per-lane writes and a registered read port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            if (be_i[0]) begin
                mem[addr_i][BYTE_WIDTH-1:0] <= wdata_i[BYTE_WIDTH-1:0];
            end
            if (be_i[1]) begin
                mem[addr_i][WORD_WIDTH-1:BYTE_WIDTH] <= wdata_i[WORD_WIDTH-1:BYTE_WIDTH];
            end
        end
        if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_unit.sv
// ---------------------------------------------------------------------------
// data_memory_unit
// Fixed-latency responder for MEM-stage loads and stores on an internal
// 16-bit data RAM. Holds the pipeline with Stall while an access is in
// flight, then presents load data for one DONE cycle.
//   Clock      : clock, rising edge
//   Reset      : synchronous, active-high
//   MemRead    : load request (LW, LBU)
//   MemWrite   : store request (SW, SB); wins if both requests are high
//   ByteOp     : 1 = byte access, 0 = word access
//   Address    : byte address
//   WriteData  : store data, low byte used for byte stores
//   ReadData   : load result, zero-extended for byte loads, held otherwise
//   Stall      : pipeline freeze while the access is pending
//   Done       : one-cycle completion pulse
//   AlignError : pulses with Done for a word access at an odd address
// ---------------------------------------------------------------------------
module data_memory_unit
    import memory_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  ByteOp,
    input  logic [15:0]           Address,
    input  logic [WORD_WIDTH-1:0] WriteData,
    output logic [WORD_WIDTH-1:0] ReadData,
    output logic                  Stall,
    output logic                  Done,
    output logic                  AlignError
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    memState_e             state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [AW:0]           addr_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic                  byteOp_q;
    logic                  isWrite_q;
    logic                  isLoad_q;
    logic [WORD_WIDTH-1:0] readData_q;

    logic                  request;
    logic                  accessNow;
    logic                  ramWe;
    logic                  ramRe;
    logic [1:0]            ramBe;
    logic [WORD_WIDTH-1:0] ramWdata;
    logic [WORD_WIDTH-1:0] ramRdata;
    logic [BYTE_WIDTH-1:0] laneByte;
    logic [WORD_WIDTH-1:0] loadValue;

    // Address bits above the RAM index wrap the access modulo DEPTH words.
    logic                  unusedAddrBits;
    assign unusedAddrBits = ^Address[15:AW+1];

    assign request = MemRead | MemWrite;

    // State, counter, request capture and the held load result.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            byteOp_q   <= 1'b0;
            isWrite_q  <= 1'b0;
            isLoad_q   <= 1'b0;
            readData_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (state_q == IDLE && request) begin
                addr_q    <= Address[AW:0];
                wdata_q   <= WriteData;
                byteOp_q  <= ByteOp;
                isWrite_q <= MemWrite;
                isLoad_q  <= MemRead & ~MemWrite;
            end
            if (state_q == DONE && isLoad_q) begin
                readData_q <= loadValue;
            end
        end
    end

    // Next state, latency countdown and the pipeline handshake outputs.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        accessNow  = 1'b0;
        Stall      = 1'b0;
        Done       = 1'b0;
        AlignError = 1'b0;
        case (state_q)
            IDLE: begin
                if (request) begin
                    Stall   = 1'b1;
                    count_d = CW'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (count_q == '0) begin
                    accessNow = 1'b1;
                    state_d   = DONE;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            DONE: begin
                Done       = 1'b1;
                AlignError = ~byteOp_q & addr_q[0];
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset on the access edge abandons the access, so the strobes are gated.
    assign ramWe    = accessNow & isWrite_q & ~Reset;
    assign ramRe    = accessNow & isLoad_q & ~Reset;
    assign ramBe    = laneEnable(byteOp_q, addr_q[0]);
    assign ramWdata = byteOp_q ? {2{wdata_q[BYTE_WIDTH-1:0]}} : wdata_q;

    data_ram #(
        .DEPTH(DEPTH)
    ) uDataRam (
        .clk_i  (Clock),
        .we_i   (ramWe),
        .be_i   (ramBe),
        .re_i   (ramRe),
        .addr_i (addr_q[AW:1]),
        .wdata_i(ramWdata),
        .rdata_o(ramRdata)
    );

    // The RAM read lands at the start of DONE, so the fresh load value is
    // driven straight out during DONE and held in readData_q afterwards.
    assign laneByte  = (addr_q[0] == LANE_HI) ? ramRdata[WORD_WIDTH-1:BYTE_WIDTH]
                                              : ramRdata[BYTE_WIDTH-1:0];
    assign loadValue = byteOp_q ? {{(WORD_WIDTH-BYTE_WIDTH){1'b0}}, laneByte} : ramRdata;
    assign ReadData  = (state_q == DONE && isLoad_q) ? loadValue : readData_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// ---------------------------------------------------------------------------
// tb_data_memory_unit
// Directed self-checking bench for data_memory_unit (DEPTH=256, LATENCY=2).
// ---------------------------------------------------------------------------
module tb_data_memory_unit;

    localparam int LATENCY = 2;

    logic        Clock;
    logic        Reset;
    logic        MemRead;
    logic        MemWrite;
    logic        ByteOp;
    logic [15:0] Address;
    logic [15:0] WriteData;
    logic [15:0] ReadData;
    logic        Stall;
    logic        Done;
    logic        AlignError;

    int errorCount = 0;
    int checkCount = 0;

    data_memory_unit #(
        .DEPTH  (256),
        .LATENCY(LATENCY)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ByteOp    (ByteOp),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .Done      (Done),
        .AlignError(AlignError)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Issues one request on a falling edge and follows it to its Done pulse,
    // checking stall length, Done position, AlignError and ReadData there.
    // Inputs stay asserted through DONE so a following call is back-to-back.
    task automatic applyStimulus(input string tag, input logic rd, input logic wr, input logic bo,
                                 input logic [15:0] addr, input logic [15:0] wd,
                                 input logic [15:0] rdExp, input logic alignExp);
        int  cyc;
        int  stalls;
        bit  seen;
        @(negedge Clock);
        MemRead   = rd;
        MemWrite  = wr;
        ByteOp    = bo;
        Address   = addr;
        WriteData = wd;
        cyc    = 0;
        stalls = 0;
        seen   = 1'b0;
        #1;
        checkOutput({tag, " doneLowAtIssue"}, {31'd0, Done}, 32'd0);
        while (!seen && cyc < 20) begin
            if (Stall) stalls++;
            if (Done) begin
                seen = 1'b1;
                checkOutput({tag, " doneCycle"}, cyc, LATENCY + 1);
                checkOutput({tag, " stallCycles"}, stalls, LATENCY + 1);
                checkOutput({tag, " alignError"}, {31'd0, AlignError}, {31'd0, alignExp});
                checkOutput({tag, " readData"}, {16'd0, ReadData}, {16'd0, rdExp});
            end else begin
                @(negedge Clock);
                #1;
                cyc++;
            end
        end
        if (!seen) begin
            checkOutput({tag, " doneTimeout"}, 32'd0, 32'd1);
        end
    endtask

    // Drops all requests for a number of cycles.
    task automatic idleCycles(input int n);
        @(negedge Clock);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ByteOp   = 1'b0;
        repeat (n) @(negedge Clock);
    endtask

    // Starts a store and asserts Reset during BUSY cycle rstCycle (1..LATENCY).
    task automatic resetDuringStore(input string tag, input logic [15:0] addr, input logic [15:0] wd,
                                    input int rstCycle);
        @(negedge Clock);
        MemRead   = 1'b0;
        MemWrite  = 1'b1;
        ByteOp    = 1'b0;
        Address   = addr;
        WriteData = wd;
        repeat (rstCycle) @(negedge Clock);
        #1;
        checkOutput({tag, " stallInBusy"}, {31'd0, Stall}, 32'd1);
        Reset    = 1'b1;
        MemWrite = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        checkOutput({tag, " stallAfterReset"}, {31'd0, Stall}, 32'd0);
        checkOutput({tag, " doneAfterReset"}, {31'd0, Done}, 32'd0);
        checkOutput({tag, " readDataAfterReset"}, {16'd0, ReadData}, 32'h0000);
        @(negedge Clock);
        #1;
        checkOutput({tag, " stillIdle"}, {30'd0, Stall, Done}, 32'd0);
    endtask

    initial begin
        Reset     = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        ByteOp    = 1'b0;
        Address   = 16'h0000;
        WriteData = 16'h0000;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        #1;
        checkOutput("reset stall", {31'd0, Stall}, 32'd0);
        checkOutput("reset done", {31'd0, Done}, 32'd0);
        checkOutput("reset alignError", {31'd0, AlignError}, 32'd0);
        checkOutput("reset readData", {16'd0, ReadData}, 32'h0000);

        // Word/byte stores and loads at word 8.
        applyStimulus("SW 0010", 1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
        applyStimulus("LW 0010", 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
        applyStimulus("LBU 0011", 1'b1, 1'b0, 1'b1, 16'h0011, 16'h0000, 16'h00BE, 1'b0);
        applyStimulus("SB 0010", 1'b0, 1'b1, 1'b1, 16'h0010, 16'h1234, 16'h00BE, 1'b0);
        applyStimulus("LW 0010 a", 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBE34, 1'b0);
        applyStimulus("LW 0010 b2b", 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBE34, 1'b0);
        applyStimulus("LBU 0010", 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0034, 1'b0);

        // Misaligned word access and address wrap.
        applyStimulus("SW 0012", 1'b0, 1'b1, 1'b0, 16'h0012, 16'hCAFE, 16'h0034, 1'b0);
        applyStimulus("LW 0013 misaligned", 1'b1, 1'b0, 1'b0, 16'h0013, 16'h0000, 16'hCAFE, 1'b1);
        applyStimulus("LW 0210 wrap", 1'b1, 1'b0, 1'b0, 16'h0210, 16'h0000, 16'hBE34, 1'b0);
        applyStimulus("SB 0013 hiLane", 1'b0, 1'b1, 1'b1, 16'h0013, 16'h77AB, 16'hBE34, 1'b0);
        applyStimulus("LW 0012", 1'b1, 1'b0, 1'b0, 16'h0012, 16'h0000, 16'hABFE, 1'b0);
        applyStimulus("SW 0211 misaligned wrap", 1'b0, 1'b1, 1'b0, 16'h0211, 16'h4321, 16'hABFE, 1'b1);
        applyStimulus("LW 0010 after wrap store", 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h4321, 1'b0);

        idleCycles(2);
        #1;
        checkOutput("idle stall", {31'd0, Stall}, 32'd0);
        checkOutput("idle readData held", {16'd0, ReadData}, 32'h4321);

        // Reset in the first and in the last BUSY cycle abandons the store.
        applyStimulus("SW 0030", 1'b0, 1'b1, 1'b0, 16'h0030, 16'h1111, 16'h4321, 1'b0);
        resetDuringStore("rst busy1", 16'h0030, 16'h7777, 1);
        applyStimulus("LW 0030 after rst1", 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'h1111, 1'b0);
        resetDuringStore("rst busyLast", 16'h0030, 16'h2222, LATENCY);
        applyStimulus("LW 0030 after rst2", 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'h1111, 1'b0);

        // Read and write together: store wins, ReadData keeps the last load.
        applyStimulus("RW 0020", 1'b1, 1'b1, 1'b0, 16'h0020, 16'h5A5A, 16'h1111, 1'b0);
        idleCycles(1);
        #1;
        checkOutput("RW readData held", {16'd0, ReadData}, 32'h1111);
        applyStimulus("LW 0020", 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h5A5A, 1'b0);

        idleCycles(2);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
